// File: rtl/can_feature_extractor_p.sv
// CAN feature extractor: per-ID history lookup producing ID, masked payload,
// inter-arrival delta and payload Hamming distance for the downstream classifier.
module can_feature_extractor_p #(
    parameter int ID_SLOTS = 8,
    parameter int TS_W     = 32,
    parameter int FEAT_W   = 64,
    parameter int MASK_STD = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_en,
    input  logic [28:0]       can_id,
    input  logic [3:0]        can_dlc,
    input  logic [63:0]       can_data,
    input  logic              frame_ext,
    input  logic              frame_valid,
    output logic              frame_ready,
    output logic [FEAT_W-1:0] feat_id,
    output logic [63:0]       feat_payload,
    output logic [FEAT_W-1:0] feat_delta,
    output logic [6:0]        feat_hdist,
    output logic              feat_hit,
    output logic              feat_valid,
    input  logic              feat_ready,
    output logic [2:0]        state,
    output logic              busy
);
    localparam int IDX_W = $clog2(ID_SLOTS);
    localparam int KEY_W = 30;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_COMPUTE = 3'd2,
        S_OUT     = 3'd3
    } state_e;

    typedef struct packed {
        logic             vld;
        logic [KEY_W-1:0] key;
        logic [TS_W-1:0]  ts;
        logic [63:0]      pay;
    } slot_t;

    state_e                       state_q;
    logic [TS_W-1:0]              ts_q, ts_cap_q;
    logic [KEY_W-1:0]             key_q;
    logic [63:0]                  pay_q;
    logic                         hit_q;
    logic [IDX_W-1:0]             idx_q, ptr_q;
    slot_t [ID_SLOTS-1:0]         slot_q;
    logic [FEAT_W-1:0]            feat_id_q, feat_delta_q;
    logic [63:0]                  feat_payload_q;
    logic [6:0]                   feat_hdist_q;
    logic                         feat_hit_q, feat_valid_q;

    logic [KEY_W-1:0]             key_in;
    logic [63:0]                  pay_in;
    logic [3:0]                   dlc_c;
    logic [ID_SLOTS-1:0]          match;
    logic                         hit_d;
    logic [IDX_W-1:0]             idx_d, wr_idx;
    slot_t                        sel;
    logic [TS_W-1:0]              delta_d;
    logic [63:0]                  diff;
    logic [6:0]                   hdist_d;

    // Standard frames share the key space with bit 29 = 0 and only the low 11 ID bits.
    always_comb begin
        key_in = {frame_ext, can_id};
        if (!frame_ext && MASK_STD != 0)
            key_in = {1'b0, 18'b0, can_id[10:0]};
        dlc_c  = (can_dlc > 4'd8) ? 4'd8 : can_dlc;
        pay_in = '0;
        for (int b = 0; b < 8; b++)
            if (4'(b) < dlc_c)
                pay_in[63-8*b -: 8] = can_data[63-8*b -: 8];
    end

    for (genvar g = 0; g < ID_SLOTS; g++) begin : g_cmp
        assign match[g] = slot_q[g].vld && (slot_q[g].key == key_q);
    end

    always_comb begin
        hit_d = |match;
        idx_d = '0;
        for (int i = 0; i < ID_SLOTS; i++)
            if (match[i])
                idx_d = IDX_W'(i);
    end

    always_comb begin
        sel     = slot_q[idx_q];
        delta_d = ts_cap_q - sel.ts;
        diff    = pay_q ^ sel.pay;
        hdist_d = '0;
        for (int i = 0; i < 64; i++)
            hdist_d = hdist_d + {6'b0, diff[i]};
        wr_idx  = hit_q ? idx_q : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ts_q           <= '0;
            ts_cap_q       <= '0;
            key_q          <= '0;
            pay_q          <= '0;
            hit_q          <= 1'b0;
            idx_q          <= '0;
            ptr_q          <= '0;
            slot_q         <= '0;
            feat_id_q      <= '0;
            feat_payload_q <= '0;
            feat_delta_q   <= '0;
            feat_hdist_q   <= '0;
            feat_hit_q     <= 1'b0;
            feat_valid_q   <= 1'b0;
        end else begin
            if (tick_en)
                ts_q <= ts_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (frame_valid) begin
                        key_q    <= key_in;
                        pay_q    <= pay_in;
                        ts_cap_q <= ts_q;
                        state_q  <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    hit_q   <= hit_d;
                    idx_q   <= idx_d;
                    state_q <= S_COMPUTE;
                end
                S_COMPUTE: begin
                    feat_id_q      <= FEAT_W'(key_q[28:0]);
                    feat_payload_q <= pay_q;
                    feat_hit_q     <= hit_q;
                    feat_delta_q   <= hit_q ? FEAT_W'(delta_d) : '1;
                    feat_hdist_q   <= hit_q ? hdist_d : 7'd0;
                    feat_valid_q   <= 1'b1;
                    slot_q[wr_idx] <= '{vld: 1'b1, key: key_q, ts: ts_cap_q, pay: pay_q};
                    // Only a new key consumes a slot, so the pointer moves on misses only.
                    if (!hit_q)
                        ptr_q <= ptr_q + 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    if (feat_ready) begin
                        feat_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign frame_ready  = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign state        = state_q;
    assign feat_id      = feat_id_q;
    assign feat_payload = feat_payload_q;
    assign feat_delta   = feat_delta_q;
    assign feat_hdist   = feat_hdist_q;
    assign feat_hit     = feat_hit_q;
    assign feat_valid   = feat_valid_q;

endmodule
